// File: rtl/aes_dec_sched.sv
// Round-robin front end that time-shares a single aes_dec core between NREQ requesters.
// One job in flight: grant, start the core, wait for done (or time out), then hold the response.
module aes_dec_sched #(
  parameter int KEY_SIZE = 128,
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int TIMEOUT  = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*128-1:0]      req_ct,
  input  logic [NREQ*KEY_SIZE-1:0] req_key,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [IDW-1:0]           resp_id,
  output logic [127:0]             resp_pt,
  output logic                     resp_err,
  output logic                     core_rst_n,
  output logic                     core_start,
  output logic [127:0]             core_ct,
  output logic [KEY_SIZE-1:0]      core_key,
  input  logic                     core_done,
  input  logic [127:0]             core_pt
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_START,
    S_WAIT,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t r_state, w_state_next;

  logic [IDW-1:0]      r_ptr, r_winner, r_id, r_resp_id;
  logic                r_first;
  logic [CW-1:0]       r_cnt;
  logic [127:0]        r_core_ct, r_resp_pt;
  logic [KEY_SIZE-1:0] r_core_key;
  logic                r_resp_err, r_core_rst_n;

  logic [IDW-1:0]      w_start, w_pick;
  logic                w_any;
  logic [NREQ-1:0]     w_hit;
  logic [IDW:0]        w_sum [NREQ];
  logic [IDW-1:0]      w_idx [NREQ];
  logic [127:0]        w_ct_arr [NREQ];
  logic [KEY_SIZE-1:0] w_key_arr [NREQ];

  // Until the first accepted job the search begins at requester 0.
  always_comb begin
    w_start = '0;
    if (!r_first && r_ptr != IDW'(NREQ - 1)) begin
      w_start = r_ptr + 1'b1;
    end
  end

  // w_idx[k] is the k-th requester in search order, i.e. (w_start + k) mod NREQ.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign w_ct_arr[gi]  = req_ct[128*gi +: 128];
      assign w_key_arr[gi] = req_key[KEY_SIZE*gi +: KEY_SIZE];
      assign w_sum[gi]     = {1'b0, w_start} + (IDW + 1)'(gi);
      assign w_idx[gi]     = (w_sum[gi] >= (IDW + 1)'(NREQ))
                             ? IDW'(w_sum[gi] - (IDW + 1)'(NREQ))
                             : w_sum[gi][IDW-1:0];
      assign w_hit[gi]     = req_valid[w_idx[gi]];
      assign req_ready[gi] = (r_state == S_GRANT) && (r_winner == IDW'(gi));
    end
  endgenerate

  always_comb begin
    w_pick = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        w_pick = w_idx[k];
      end
    end
  end

  assign w_any = |req_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:    if (w_any) w_state_next = S_GRANT;
      S_GRANT:   w_state_next = req_valid[r_winner] ? S_START : S_IDLE;
      S_START:   w_state_next = S_WAIT;
      S_WAIT: begin
        if (core_done) begin
          w_state_next = S_CAPTURE;
        end else if (r_cnt == TO_LAST) begin
          w_state_next = S_RESP;
        end
      end
      S_CAPTURE: w_state_next = S_RESP;
      S_RESP:    if (resp_ready) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_first    <= 1'b1;
      r_winner   <= '0;
      r_id       <= '0;
      r_cnt      <= '0;
      r_core_ct  <= '0;
      r_core_key <= '0;
      r_resp_id  <= '0;
      r_resp_pt  <= '0;
      r_resp_err <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_any) r_winner <= w_pick;
        S_GRANT: begin
          // Payload is taken only if the winner still holds valid on its grant cycle.
          if (req_valid[r_winner]) begin
            r_core_ct  <= w_ct_arr[r_winner];
            r_core_key <= w_key_arr[r_winner];
            r_id       <= r_winner;
            r_ptr      <= r_winner;
            r_first    <= 1'b0;
          end
        end
        S_START: r_cnt <= '0;
        S_WAIT: begin
          if (!core_done) begin
            if (r_cnt == TO_LAST) begin
              r_resp_err <= 1'b1;
              r_resp_pt  <= '0;
              r_resp_id  <= r_id;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_CAPTURE: begin
          r_resp_pt  <= core_pt;
          r_resp_err <= 1'b0;
          r_resp_id  <= r_id;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    r_core_rst_n <= ~rst;
  end

  assign core_rst_n = r_core_rst_n;
  assign core_start = (r_state == S_START);
  assign core_ct    = r_core_ct;
  assign core_key   = r_core_key;
  assign resp_valid = (r_state == S_RESP);
  assign resp_id    = r_resp_id;
  assign resp_pt    = r_resp_pt;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_aes_dec_sched.sv
// Scoreboarded bench for aes_dec_sched with a behavioural core (FIPS-197 vector, else ct^key).
// Expected responses are queued at grant time; a negedge monitor pops them on each handshake.
module tb_aes_dec_sched;
  localparam int KEY_SIZE = 128;
  localparam int NREQ     = 4;
  localparam int IDW      = 2;
  localparam int TIMEOUT  = 15;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ*128-1:0]      req_ct;
  logic [NREQ*KEY_SIZE-1:0] req_key;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [IDW-1:0]           resp_id;
  logic [127:0]             resp_pt;
  logic                     resp_err;
  logic                     core_rst_n;
  logic                     core_start;
  logic [127:0]             core_ct;
  logic [KEY_SIZE-1:0]      core_key;
  logic                     core_done = 1'b0;
  logic [127:0]             core_pt;
  logic                     done_en = 1'b1;

  typedef struct {
    logic [IDW-1:0] id;
    logic [127:0]   pt;
    logic           err;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [127:0] ct_tab  [NREQ];
  logic [127:0] key_tab [NREQ];

  always #5 clk = ~clk;

  aes_dec_sched #(
    .KEY_SIZE(KEY_SIZE), .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_ct(req_ct), .req_key(req_key),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_pt(resp_pt), .resp_err(resp_err),
    .core_rst_n(core_rst_n), .core_start(core_start), .core_ct(core_ct),
    .core_key(core_key), .core_done(core_done), .core_pt(core_pt)
  );

  function automatic logic [127:0] core_model(input logic [127:0] ct, input logic [127:0] key);
    if (ct == FIPS_CT && key == FIPS_KEY) return FIPS_PT;
    return ct ^ key;
  endfunction

  function automatic logic [127:0] exp_pt_of(input int i);
    if (i == 0) return FIPS_PT;
    return ct_tab[i] ^ key_tab[i];
  endfunction

  assign core_pt = core_model(core_ct, core_key);

  // Core answers one cycle after start unless done_en is cleared (timeout scenario).
  always @(posedge clk) core_done <= done_en && core_start;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  128'(req_ready),  128'(0));
    chk({tag, "_resp_valid"}, 128'(resp_valid), 128'(0));
    chk({tag, "_resp_id"},    128'(resp_id),    128'(0));
    chk({tag, "_resp_pt"},    resp_pt,          128'(0));
    chk({tag, "_resp_err"},   128'(resp_err),   128'(0));
    chk({tag, "_core_start"}, 128'(core_start), 128'(0));
    chk({tag, "_core_ct"},    core_ct,          128'(0));
    chk({tag, "_core_key"},   128'(core_key),   128'(0));
    chk({tag, "_core_rst_n"}, 128'(core_rst_n), 128'(0));
  endtask

  task automatic wait_grant(input logic [NREQ-1:0] exp_ready);
    int n;
    n = 0;
    while (req_ready == '0 && n < 20) begin
      step();
      n++;
    end
    chk("grant", 128'(req_ready), 128'(exp_ready));
  endtask

  // Called in the grant cycle; returns in the first cycle resp_valid is seen.
  task automatic do_job(input int id, input bit err, input int exp_lat);
    exp_t e;
    int   lat;
    e.id  = IDW'(id);
    e.pt  = err ? 128'(0) : exp_pt_of(id);
    e.err = err;
    exp_q.push_back(e);
    lat = 0;
    do begin
      step();
      lat++;
      if (lat == 1) begin
        chk("core_start", 128'(core_start), 128'(1));
        chk("ready_pulse", 128'(req_ready), 128'(0));
      end
      if (lat == 2) chk("start_pulse", 128'(core_start), 128'(0));
      if (lat <= 3) chk("core_ct_hold", core_ct, ct_tab[id]);
    end while (!resp_valid && lat < 60);
    chk("latency", 128'(lat), 128'(exp_lat));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected actual id=%0d pt=%h err=%0d required none",
                 resp_id, resp_pt, resp_err);
      end else begin
        e = exp_q.pop_front();
        $display("resp id=%0d pt=%h err=%0d", resp_id, resp_pt, resp_err);
        chk("resp_id",  128'(resp_id),  128'(e.id));
        chk("resp_pt",  resp_pt,        e.pt);
        chk("resp_err", 128'(resp_err), 128'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int id;
    ct_tab[0]  = FIPS_CT;
    key_tab[0] = FIPS_KEY;
    ct_tab[1]  = 128'h0123456789abcdeffedcba9876543210;
    key_tab[1] = 128'hffffffff00000000ffffffff00000000;
    ct_tab[2]  = 128'hdeadbeef00000000cafef00d12345678;
    key_tab[2] = 128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a;
    ct_tab[3]  = 128'h89abcdef0123456776543210fedcba98;
    key_tab[3] = 128'h00000000000000000000000000000001;
    req_ct     = {ct_tab[3], ct_tab[2], ct_tab[1], ct_tab[0]};
    req_key    = {key_tab[3], key_tab[2], key_tab[1], key_tab[0]};
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b1;

    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();
    chk("core_rst_n_release", 128'(core_rst_n), 128'(1));

    // Single FIPS-197 job from requester 0
    req_valid = 4'b0001;
    wait_grant(4'b0001);
    do_job(0, 1'b0, 4);
    req_valid = '0;
    step();

    // All requesters valid from a fresh pointer: grants 0,1,2,3,0
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    req_valid = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      id = j % 4;
      wait_grant(NREQ'(1) << id);
      do_job(id, 1'b0, 4);
      if (j == 4) req_valid = '0;
      step();
    end

    // Backpressure: response held for 10 cycles while requester 3 waits
    resp_ready = 1'b0;
    req_valid  = 4'b1010;
    wait_grant(4'b0010);
    do_job(1, 1'b0, 4);
    for (int j = 0; j < 10; j++) begin
      chk("bp_valid", 128'(resp_valid), 128'(1));
      chk("bp_pt",    resp_pt,          exp_pt_of(1));
      chk("bp_id",    128'(resp_id),    128'(1));
      chk("bp_ready", 128'(req_ready),  128'(0));
      step();
    end
    resp_ready = 1'b1;
    req_valid  = 4'b1000;
    step();
    chk("bp_release", 128'(resp_valid), 128'(0));
    wait_grant(4'b1000);
    do_job(3, 1'b0, 4);
    req_valid = '0;
    step();

    // Timeout: core never answers, then a normal job follows
    done_en   = 1'b0;
    req_valid = 4'b0100;
    wait_grant(4'b0100);
    do_job(2, 1'b1, 2 + TIMEOUT);
    req_valid = '0;
    done_en   = 1'b1;
    step();
    req_valid = 4'b0001;
    wait_grant(4'b0001);
    do_job(0, 1'b0, 4);
    req_valid = '0;
    step();

    // Requester 2 drops valid on its grant cycle; pointer must stay at 0
    req_valid = 4'b0100;
    wait_grant(4'b0100);
    req_valid = '0;
    for (int j = 0; j < 3; j++) begin
      step();
      chk("drop_no_start", 128'(core_start), 128'(0));
      chk("drop_no_ready", 128'(req_ready),  128'(0));
    end
    req_valid = 4'b1010;
    wait_grant(4'b0010);
    do_job(1, 1'b0, 4);
    req_valid = '0;
    step();

    // Reset while waiting on the core; that job must never respond
    req_valid = 4'b1000;
    wait_grant(4'b1000);
    step();
    step();
    chk("midrst_in_wait", 128'(core_start), 128'(0));
    rst = 1'b1;
    step();
    check_reset_outputs("midrst");
    req_valid = '0;
    step();
    rst = 1'b0;
    repeat (20) step();
    req_valid = 4'b0010;
    wait_grant(4'b0010);
    do_job(1, 1'b0, 4);
    req_valid = '0;
    step();
    step();

    chk("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_dec_sched.md
Name: aes_dec_sched

Overview:
- Round-robin scheduler that shares one aes_dec core between NREQ requesters.
- Accepts (ct, key) jobs over valid/ready, sequences the core's start/done protocol and holds core inputs stable for the whole operation.
- Returns plaintext tagged with the requester id over a valid/ready response port.
- Sits between the system request fabric and a single aes_dec instance.

Parameters:
- KEY_SIZE, 128, key width; must match the core (128/192/256).
- NREQ, 4, number of requesters, 2..8.
- IDW, 2, requester id width, equal to clog2(NREQ).
- TIMEOUT, 15, max cycles to wait for core_done after core_start before aborting.

Ports:
- clk  in  1  clock, single domain.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester job valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_ct  in  NREQ*128  ciphertext; slice i is bits [128*i+127:128*i].
- req_key  in  NREQ*KEY_SIZE  key; slice i is bits [KEY_SIZE*i+KEY_SIZE-1:KEY_SIZE*i].
- resp_valid  out  1  plaintext response valid.
- resp_ready  in  1  response consumer ready.
- resp_id  out  IDW  requester index of the response.
- resp_pt  out  128  plaintext.
- resp_err  out  1  response is a timeout abort; resp_pt is 0 when set.
- core_rst_n  out  1  active-low core reset, driven as registered ~rst.
- core_start  out  1  core start pulse.
- core_ct  out  128  core ciphertext input.
- core_key  out  KEY_SIZE  core key input.
- core_done  in  1  core done flag.
- core_pt  in  128  core plaintext.

Behaviour:
- Reset values: req_ready=0, resp_valid=0, resp_id=0, resp_pt=0, resp_err=0, core_start=0, core_ct=0, core_key=0, core_rst_n=0. Round-robin pointer = 0, FSM = IDLE.
- core_rst_n goes 1 on the first clock edge after rst deasserts.
- FSM states: IDLE, GRANT, START, WAIT, CAPTURE, RESP.
- IDLE: if any req_valid, choose the winner by round-robin starting at pointer+1 (mod NREQ); after reset the search starts at index 0. Go to GRANT.
- GRANT: req_ready[winner]=1 for exactly this one cycle. req_valid[winner] is sampled here.
  - If still high: latch ct/key into core_ct/core_key, store the id, set pointer=winner, go to START.
  - If dropped: no transfer, return to IDLE, pointer unchanged.
- START: core_start=1 for exactly one cycle, go to WAIT. The timeout counter is cleared.
- WAIT:
  - core_ct/core_key are held constant; the core's datapath is combinational on its ct input.
  - When core_done=1 is sampled, go to CAPTURE.
  - The counter increments each cycle. If it reaches TIMEOUT with no done, load resp_err=1, resp_pt=0, and go to RESP.
- CAPTURE: one cycle with inputs still held. On the next edge, resp_pt<=core_pt, resp_err<=0, resp_id<=stored id, go to RESP. Plaintext is therefore captured two cycles after the start edge.
- RESP: resp_valid=1. resp_id/resp_pt/resp_err are stable until resp_valid && resp_ready is sampled.
  - Then resp_valid drops, and the next state is IDLE.
  - No new grant is issued while a response is pending; there is one job in flight maximum.
- Nominal latency: GRANT edge to resp_valid is 4 cycles (START, WAIT, CAPTURE, RESP).
- Simultaneous requests: exactly one grant. A requester holding valid is served within NREQ jobs (no starvation).
- req_valid changes outside GRANT are ignored. Payloads are sampled only in GRANT.
- core_done high in IDLE is ignored.
- rst asserted mid-operation: all state and outputs return to reset values on that edge and any in-flight job is dropped silently. core_rst_n=0 resets the core.
- resp_ready held high in RESP: the handshake completes in one cycle.

Test Plan:
- Single job: req_valid[0]=1, FIPS-197 AES-128 key 000102..0f, ct 69c4e0d8..c55a.
  - Expect req_ready[0] pulse, core_start 1 cycle later, resp_valid 4 cycles after grant.
  - Expect resp_pt=00112233..ccddeeff, resp_id=0, resp_err=0.
- All four requesters valid continuously, resp_ready=1: grants occur in order 0,1,2,3,0.
  - Each resp_id matches its grant; core_ct is constant from START through CAPTURE.
- Backpressure: resp_ready=0 for 10 cycles in RESP.
  - resp_valid/resp_pt/resp_id stay stable and req_ready stays 0 throughout.
  - The handshake completes on the cycle resp_ready=1.
- Timeout: bench core model never asserts core_done.
  - Expect resp_valid with resp_err=1, resp_pt=0 exactly TIMEOUT cycles after WAIT entry.
  - The next job then proceeds normally.
- Valid drop in GRANT: req_valid[2] deasserts on the grant cycle.
  - Expect no core_start, a return to IDLE, and an unchanged pointer.
- Mid-operation reset: assert rst in WAIT.
  - Next cycle all outputs are at reset values, core_rst_n=0, and no response is ever emitted for that job.
